// File: rtl/mdu_hilo_unit.sv
// ----------------------------------------------------------------------------
// mdu_hilo_unit
//   Multiply sequencer and HI/LO register file for the MIPS execute stage.
//   Accepts MULT/MULTU, converts signed operands to magnitudes, runs them
//   through a single-cycle unsigned 32x32 multiplier, re-applies the sign and
//   commits the 64-bit result to {hi,lo}. Also serves MTHI/MTLO writes.
//
//   Ports:
//     clk, rst_n        clock, asynchronous active-low reset
//     start             launch a multiply (sampled only when idle)
//     is_signed         1 = MULT, 0 = MULTU (sampled with start)
//     op_a, op_b        32-bit operands (sampled with start)
//     cancel            abort an in-flight multiply (wins over start)
//     mthi, mtlo        write wdata to HI / LO when not busy
//     wdata             MTHI/MTLO data
//     busy              multiply in flight
//     done              one-cycle pulse after HI/LO took a product
//     hi, lo            HI / LO registers
// ----------------------------------------------------------------------------

// Combinational unsigned 32x32 -> 64 multiplier.
module multiplier32bit_single_stage (
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [63:0] p
);
   assign p = {32'b0, a} * {32'b0, b};
endmodule

module mdu_hilo_unit (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] op_a,
   input  logic [31:0] op_b,
   input  logic        cancel,
   input  logic        mthi,
   input  logic        mtlo,
   input  logic [31:0] wdata,
   output logic        busy,
   output logic        done,
   output logic [31:0] hi,
   output logic [31:0] lo
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_MUL,
      S_FIX
   } state_t;

   state_t      state, state_nxt;

   logic [31:0] mag_a, mag_b;
   logic        neg;
   logic [63:0] prod_r;
   logic [63:0] prod_w;
   logic [63:0] result;
   logic [31:0] abs_a, abs_b;
   logic        launch;
   logic        commit;

   // ---------------------------------------------------------------- state reg
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= S_IDLE;
      else        state <= state_nxt;
   end

   // ---------------------------------------------------------------- next state
   always_comb begin
      state_nxt = state;
      unique case (state)
         S_IDLE:  if (start && !cancel) state_nxt = S_MUL;
         S_MUL:   state_nxt = cancel ? S_IDLE : S_FIX;
         S_FIX:   state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // ---------------------------------------------------------------- outputs
   always_comb begin
      busy   = (state != S_IDLE);
      launch = (state == S_IDLE) && start && !cancel;
      commit = (state == S_FIX) && !cancel;
   end

   // Magnitudes: 0x80000000 negates to itself, which read as unsigned is 2^31.
   always_comb begin
      abs_a = (is_signed && op_a[31]) ? (~op_a + 32'd1) : op_a;
      abs_b = (is_signed && op_b[31]) ? (~op_b + 32'd1) : op_b;
   end

   multiplier32bit_single_stage u_mul (
      .a (mag_a),
      .b (mag_b),
      .p (prod_w)
   );

   // Max magnitude product is 2^62, so negation cannot overflow.
   assign result = neg ? (~prod_r + 64'd1) : prod_r;

   // ---------------------------------------------------------------- datapath
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         mag_a  <= '0;
         mag_b  <= '0;
         neg    <= 1'b0;
         prod_r <= '0;
         done   <= 1'b0;
         hi     <= '0;
         lo     <= '0;
      end else begin
         if (launch) begin
            mag_a <= abs_a;
            mag_b <= abs_b;
            neg   <= is_signed & (op_a[31] ^ op_b[31]);
         end
         if (state == S_MUL) prod_r <= prod_w;
         done <= commit;
         // Commit only happens while busy, MT writes only while idle,
         // so the two never collide.
         if (commit) begin
            hi <= result[63:32];
            lo <= result[31:0];
         end else if (!busy) begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
         end
      end
   end

endmodule
